counter_sequencer: RTL and testbench

- Command-driven controller for the 4-mode counter (modes: up-by-3, down-by-1, up-by-1, load).
- Accepts {mode, load value, length} commands over a valid/ready handshake and buffers them in a small FIFO.
- Executes commands one at a time by driving the counter's enable/reset/mode/data inputs, counts ripple-carry events and checks load acknowledge.
- Sits between the test/stimulus or host logic and one counter instance.

---
 rtl/counter_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Command-driven controller for one 4-mode counter (00 up-by-3, 01 down-by-1,
// 10 up-by-1, 11 load). Commands {mode, load value, length} enter a small FIFO
// over a valid/ready handshake and are executed strictly in order: the FSM
// drives the counter's enable/reset/mode/data lines for the requested number of
// enabled cycles, counts ripple-carry events, captures the final Q value and
// checks the load acknowledge.
//
// Ports
//   clk        single clock, rising edge
//   RESET_L    asynchronous active-low reset
//   CLEAR      re-initialise the counter (honoured only in IDLE)
//   CMD_VALID / CMD_READY / CMD_MODO / CMD_D / CMD_LEN   command handshake
//   C_ENABLE / C_RESET / C_MODO / C_D                    counter controls
//   C_Q / C_RCO / C_LOAD                                 counter status
//   BUSY       FSM active or commands queued
//   DONE       one-cycle pulse at command completion
//   RCO_CNT    RCO events of the last/current command (saturating)
//   LAST_Q     counter value registered at the final enabled edge
//   ERR        sticky load-acknowledge failure
// -----------------------------------------------------------------------------
module counter_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 6
) (
   input  logic             clk,
   input  logic             RESET_L,
   input  logic             CLEAR,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_MODO,
   input  logic [3:0]       CMD_D,
   input  logic [LEN_W-1:0] CMD_LEN,
   output logic             C_ENABLE,
   output logic             C_RESET,
   output logic [1:0]       C_MODO,
   output logic [3:0]       C_D,
   input  logic [3:0]       C_Q,
   input  logic             C_RCO,
   input  logic             C_LOAD,
   output logic             BUSY,
   output logic             DONE,
   output logic [7:0]       RCO_CNT,
   output logic [3:0]       LAST_Q,
   output logic             ERR
);

   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] ST_INIT  = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   // ---------------- command FIFO ----------------
   logic [1:0]       fifo_mode_q [FIFO_DEPTH];
   logic [3:0]       fifo_d_q    [FIFO_DEPTH];
   logic [LEN_W-1:0] fifo_len_q  [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push, pop, fifo_empty;

   // ---------------- FSM / datapath ----------------
   logic [2:0]       state_q, state_d;
   logic [1:0]       init_cnt_q, init_cnt_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             cmd_ready_q, busy_q, done_q, err_q;
   logic             c_enable_q, c_reset_q;
   logic [1:0]       c_modo_q;
   logic [3:0]       c_d_q;
   logic             en_seen_q;   // C_ENABLE as the counter sampled it at the previous edge
   logic [7:0]       rco_cnt_q;
   logic [3:0]       last_q_q;

   // CMD_READY is registered, so a full FIFO refuses a push even if a pop
   // happens in the same cycle.
   assign push       = CMD_VALID && cmd_ready_q;
   assign pop        = (state_q == ST_ISSUE);
   assign fifo_empty = (count_q == '0);

   // NOTE: every signal written in a combinational block gets a default first,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rem_d      = rem_q;
      case (state_q)
         ST_INIT: begin
            // The reset state enters with count 0 (C_RESET still low), an
            // IDLE->INIT entry with count 1; either way C_RESET is high 2 cycles.
            if (init_cnt_q == 2'd2) begin
               state_d = ST_IDLE;
            end else begin
               init_cnt_d = init_cnt_q + 2'd1;
            end
         end
         ST_IDLE: begin
            if (CLEAR) begin
               state_d    = ST_INIT;
               init_cnt_d = 2'd1;
            end else if (!fifo_empty) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A load only ever needs one enabled edge, whatever length it asked for.
            if (fifo_mode_q[rd_ptr_q] == 2'b11) begin
               rem_d = LEN_W'(1);
            end else begin
               rem_d = fifo_len_q[rd_ptr_q];
            end
            state_d = (rem_d == '0) ? ST_DRAIN : ST_RUN;
         end
         ST_RUN: begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = (!fifo_empty && !CLEAR) ? ST_ISSUE : ST_IDLE;
         end
         default: begin
            state_d    = ST_INIT;
            init_cnt_d = 2'd0;
         end
      endcase
   end

   // NOTE: the FIFO storage has no reset; emptiness is tracked by the pointers
   // and count, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mode_q[wr_ptr_q] <= CMD_MODO;
         fifo_d_q[wr_ptr_q]    <= CMD_D;
         fifo_len_q[wr_ptr_q]  <= CMD_LEN;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= 2'd0;
         rem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         c_enable_q  <= 1'b0;
         c_reset_q   <= 1'b0;
         c_modo_q    <= 2'b00;
         c_d_q       <= 4'd0;
         en_seen_q   <= 1'b0;
         rco_cnt_q   <= 8'd0;
         last_q_q    <= 4'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rem_q       <= rem_d;
         count_q     <= count_d;
         cmd_ready_q <= (count_d != DEPTH_C);
         busy_q      <= (state_d != ST_IDLE) || (count_d != '0);
         done_q      <= (state_d == ST_DRAIN);
         c_enable_q  <= (state_d == ST_RUN);
         c_reset_q   <= (state_d == ST_INIT);
         en_seen_q   <= c_enable_q;

         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            c_modo_q <= fifo_mode_q[rd_ptr_q];
            c_d_q    <= fifo_d_q[rd_ptr_q];
         end

         // Counter status is registered inside the counter, so it is only
         // meaningful one edge after an enabled edge (this includes DRAIN).
         if (state_q == ST_ISSUE) begin
            rco_cnt_q <= 8'd0;
         end else if (en_seen_q && C_RCO && (rco_cnt_q != 8'hFF)) begin
            rco_cnt_q <= rco_cnt_q + 8'd1;
         end

         if ((state_q == ST_DRAIN) && en_seen_q) begin
            last_q_q <= C_Q;
         end
         if ((state_q == ST_DRAIN) && (c_modo_q == 2'b11) && !C_LOAD) begin
            err_q <= 1'b1;
         end
      end
   end

   assign CMD_READY = cmd_ready_q;
   assign C_ENABLE  = c_enable_q;
   assign C_RESET   = c_reset_q;
   assign C_MODO    = c_modo_q;
   assign C_D       = c_d_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign RCO_CNT   = rco_cnt_q;
   assign LAST_Q    = last_q_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Drives counter_sequencer against a behavioural model of the 4-mode counter.
// Command records carry their expected results; accepted commands are queued
// and checked when the DUT pulses DONE (enable count, gap, RCO_CNT, LAST_Q,
// ERR). Hand-written sequences cover INIT length, FIFO full, reset mid-run and
// CLEAR.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

   localparam int LEN_W = 6;

   logic             clk = 1'b0;
   logic             RESET_L, CLEAR, CMD_VALID;
   logic [1:0]       CMD_MODO;
   logic [3:0]       CMD_D;
   logic [LEN_W-1:0] CMD_LEN;
   logic             CMD_READY, C_ENABLE, C_RESET, BUSY, DONE, ERR;
   logic [1:0]       C_MODO;
   logic [3:0]       C_D, LAST_Q;
   logic [7:0]       RCO_CNT;
   wire  [3:0]       C_Q;
   logic             C_RCO, C_LOAD;

   counter_sequencer #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
      .clk(clk), .RESET_L(RESET_L), .CLEAR(CLEAR),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_MODO(CMD_MODO),
      .CMD_D(CMD_D), .CMD_LEN(CMD_LEN),
      .C_ENABLE(C_ENABLE), .C_RESET(C_RESET), .C_MODO(C_MODO), .C_D(C_D),
      .C_Q(C_Q), .C_RCO(C_RCO), .C_LOAD(C_LOAD),
      .BUSY(BUSY), .DONE(DONE), .RCO_CNT(RCO_CNT), .LAST_Q(LAST_Q), .ERR(ERR)
   );

   always #5 clk = ~clk;

   // ---------------- counter model ----------------
   logic [3:0] m_q     = 4'd0;
   logic       m_valid = 1'b0;
   logic       m_rco   = 1'b0;
   logic       m_load  = 1'b0;
   bit         force_load_low = 1'b0;

   always @(posedge clk) begin
      if (C_RESET) begin
         m_q <= 4'd0; m_valid <= 1'b0; m_rco <= 1'b0; m_load <= 1'b0;
      end else if (C_ENABLE) begin
         m_valid <= 1'b1;
         m_load  <= (C_MODO == 2'b11) && !force_load_low;
         case (C_MODO)
            2'b00:   {m_rco, m_q} <= {1'b0, m_q} + 5'd3;
            2'b01:   begin m_q <= m_q - 4'd1; m_rco <= (m_q == 4'd0); end
            2'b10:   {m_rco, m_q} <= {1'b0, m_q} + 5'd1;
            default: begin m_q <= C_D; m_rco <= 1'b0; end
         endcase
      end else begin
         m_valid <= 1'b0; m_rco <= 1'b0; m_load <= 1'b0;
      end
   end

   assign C_Q    = m_valid ? m_q : 4'bz;
   assign C_RCO  = m_rco;
   assign C_LOAD = m_load;

   // ---------------- vectors and scoreboard ----------------
   typedef struct {
      logic [1:0]       mode;
      logic [3:0]       d;
      logic [LEN_W-1:0] len;
      int               exp_en;
      int               exp_rco;
      int               exp_last;
      int               exp_err;
      bit               chk_gap;
      bit               nold;     // hold the counter's LOAD acknowledge low
   } vec_t;

   vec_t sb[$];
   vec_t cur;
   vec_t tbl_b[7];
   vec_t tbl_s[6];
   int   total = 0;
   int   bad   = 0;
   int   cyc = 0, en_cnt = 0, last_done_cyc = 0;
   bit   pending = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Completion monitor: sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (!RESET_L) begin
         en_cnt  = 0;
         pending = 1'b0;
      end else begin
         if (pending) begin
            check("rco_cnt", RCO_CNT, cur.exp_rco);
            check("last_q",  LAST_Q,  cur.exp_last);
            check("err",     ERR,     cur.exp_err);
            pending = 1'b0;
         end
         if (C_ENABLE) begin
            if (en_cnt == 0 && sb.size() > 0) begin
               check("c_modo", C_MODO, sb[0].mode);
               if (sb[0].mode == 2'b11) check("c_d", C_D, sb[0].d);
            end
            en_cnt++;
         end
         if (DONE) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               cur = sb.pop_front();
               check("en_cycles", en_cnt, cur.exp_en);
               if (cur.chk_gap) check("done_gap", cyc - last_done_cyc, 2 + cur.exp_en);
               pending = 1'b1;
            end
            en_cnt        = 0;
            last_done_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send_cmd(input vec_t v);
      bit ok = 1'b0;
      @(negedge clk);
      CMD_VALID = 1'b1; CMD_MODO = v.mode; CMD_D = v.d; CMD_LEN = v.len;
      for (int k = 0; k < 500; k++) begin
         if (CMD_READY) begin
            @(posedge clk);
            sb.push_back(v);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("cmd_accepted", ok, 1);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      CMD_VALID = 1'b0;
   endtask

   // Counts C_RESET-high cycles over the next 6 cycles; also releases CLEAR.
   task automatic measure_init(input string name);
      int n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         CLEAR = 1'b0;
         if (C_RESET) n++;
      end
      check(name, n, 2);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!BUSY && sb.size() == 0 && !pending) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", ok, 1);
   endtask

   task automatic wait_enable();
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (C_ENABLE) begin
            ok = 1'b1;
            break;
         end
      end
      check("enable_seen", ok, 1);
   endtask

   task automatic do_clear(input string name);
      @(negedge clk);
      CLEAR = 1'b1;
      measure_init(name);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      //           mode   d     len    en rco last err gap nold
      tbl_b[0] = '{2'd2, 4'd0, 6'd16, 16, 1,  0,   0,  0,  0};
      tbl_b[1] = '{2'd0, 4'd0, 6'd7,  7,  1,  5,   0,  0,  0};
      tbl_b[2] = '{2'd1, 4'd0, 6'd2,  2,  1,  14,  0,  0,  0};
      tbl_b[3] = '{2'd3, 4'd9, 6'd20, 1,  0,  9,   0,  0,  0};
      tbl_b[4] = '{2'd0, 4'd0, 6'd5,  5,  0,  15,  0,  0,  0};
      tbl_b[5] = '{2'd3, 4'd9, 6'd20, 1,  0,  9,   1,  0,  1};
      tbl_b[6] = '{2'd1, 4'd0, 6'd1,  1,  1,  15,  1,  0,  0};
      // FIFO stress: first entry runs while the other five are pushed.
      tbl_s[0] = '{2'd2, 4'd0, 6'd20, 20, 1,  4,   1,  0,  0};
      tbl_s[1] = '{2'd2, 4'd0, 6'd4,  4,  0,  8,   1,  1,  0};
      tbl_s[2] = '{2'd0, 4'd0, 6'd3,  3,  1,  1,   1,  1,  0};
      tbl_s[3] = '{2'd1, 4'd0, 6'd0,  0,  0,  1,   1,  1,  0};
      tbl_s[4] = '{2'd3, 4'd6, 6'd0,  1,  0,  6,   1,  1,  0};
      tbl_s[5] = '{2'd2, 4'd0, 6'd1,  1,  0,  7,   1,  1,  0};

      RESET_L = 1'b1; CLEAR = 1'b0; CMD_VALID = 1'b0;
      CMD_MODO = 2'd0; CMD_D = 4'd0; CMD_LEN = '0;
      #2 RESET_L = 1'b0;
      #1;
      check("rst_cmd_ready", CMD_READY, 0);
      check("rst_c_enable",  C_ENABLE,  0);
      check("rst_c_reset",   C_RESET,   0);
      check("rst_busy",      BUSY,      0);
      check("rst_outputs",   {DONE, ERR, RCO_CNT, LAST_Q, C_MODO, C_D}, 0);
      repeat (2) @(negedge clk);
      RESET_L = 1'b1;
      measure_init("init_after_reset");
      check("ready_after_init", CMD_READY, 1);
      check("busy_after_init",  BUSY,      0);

      // Single commands, each from a freshly cleared counter.
      for (int i = 0; i < 7; i++) begin
         do_clear("init_on_clear");
         force_load_low = tbl_b[i].nold;
         send_cmd(tbl_b[i]);
         drop_valid();
         wait_idle();
         force_load_low = 1'b0;
      end

      // FIFO full and back-to-back execution.
      do_clear("init_on_clear");
      send_cmd(tbl_s[0]);
      drop_valid();
      wait_enable();
      for (int i = 1; i < 5; i++) send_cmd(tbl_s[i]);
      @(negedge clk);
      CMD_VALID = 1'b0;
      check("ready_when_full", CMD_READY, 0);
      check("busy_when_full",  BUSY,      1);
      send_cmd(tbl_s[5]);
      drop_valid();
      wait_idle();

      // Reset in the middle of a run with a command still queued.
      do_clear("init_on_clear");
      send_cmd('{2'd2, 4'd0, 6'd30, 30, 0, 0, 0, 0, 0});
      send_cmd('{2'd0, 4'd0, 6'd2,  2,  0, 0, 0, 0, 0});
      drop_valid();
      wait_enable();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 RESET_L = 1'b0;
      #1;
      check("midrun_c_enable",  C_ENABLE,  0);
      check("midrun_busy",      BUSY,      0);
      check("midrun_cmd_ready", CMD_READY, 0);
      check("midrun_err",       ERR,       0);
      sb.delete();
      repeat (2) @(negedge clk);
      RESET_L = 1'b1;
      measure_init("init_after_midrun_reset");
      check("fifo_flushed_busy",  BUSY,      0);
      check("fifo_flushed_ready", CMD_READY, 1);
      repeat (5) @(negedge clk);
      check("no_done_after_flush", DONE, 0);
      do_clear("clear_reruns_init");
      check("idle_after_clear", BUSY, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
